// File: rtl/softex_pkg.sv
// Shared types and constants for the softex lane sequencer slice.
package softex_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned VECT_WIDTH = 4;
  localparam int unsigned LEN_WIDTH  = 32;
  // Wide enough to hold a final-beat element count of 0..VECT_WIDTH.
  localparam int unsigned CNT_WIDTH  = $clog2(VECT_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  // Per-lane job geometry: beat count and number of valid elements in the final beat.
  typedef struct packed {
    logic [LEN_WIDTH-1:0] beats;
    logic [CNT_WIDTH-1:0] last_cnt;
  } lane_geom_t;

  // Thermometer mask with the lowest cnt elements set.
  function automatic logic [VECT_WIDTH-1:0] cnt_to_mask(input logic [CNT_WIDTH-1:0] cnt);
    logic [VECT_WIDTH-1:0] mask;
    for (int k = 0; k < VECT_WIDTH; k++) begin
      mask[k] = (CNT_WIDTH'(k) < cnt);
    end
    return mask;
  endfunction

endpackage

// File: rtl/softex_lane_beat_counter.sv
// One lane's beat counter: counts accepted handshakes, produces last/strobe
// for the current beat and flags handshakes that arrive with no beats left.
module softex_lane_beat_counter
  import softex_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  lane_geom_t            geom_i,
  input  logic                  cnt_en_i,
  input  logic                  run_i,
  input  logic                  valid_i,
  input  logic                  ready_i,
  output logic                  active_o,
  output logic                  fin_o,
  output logic                  last_o,
  output logic [VECT_WIDTH-1:0] strb_o,
  output logic                  err_o
);

  lane_geom_t           geom_q;
  logic [LEN_WIDTH-1:0] count_q;
  logic [LEN_WIDTH-1:0] count_d;
  logic                 hs;
  logic                 at_end;

  assign hs       = cnt_en_i & valid_i & ready_i;
  assign at_end   = (count_q == geom_q.beats);
  assign active_o = (geom_q.beats != '0);
  // An inactive lane has beats == count == 0, so it lands here as well.
  assign err_o    = hs & at_end;
  // Looks at the next count so the sequencer can leave RUN on the final handshake.
  assign fin_o    = (count_d == geom_q.beats);
  assign last_o   = run_i & active_o & (count_q == (geom_q.beats - LEN_WIDTH'(1)));
  assign strb_o   = (run_i & active_o) ? (last_o ? cnt_to_mask(geom_q.last_cnt) : '1) : '0;

  // Next count: advance on a handshake unless the lane is already complete.
  always_comb begin
    count_d = count_q;
    if (hs && !at_end) begin
      count_d = count_q + LEN_WIDTH'(1);
    end
  end

  // Geometry is captured on an accepted start; the count restarts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      geom_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      geom_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      geom_q  <= geom_i;
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/softex_lane_sequencer.sv
// Per-job sequencer for the softex datapath lanes: splits a job length into
// per-lane beat counts and final-beat masks, tracks lane handshakes and
// completions, and pulses done once every active lane has finished.
// Lane streams use valid/ready: a beat transfers in a cycle where both are
// high; this block only observes the handshake, it never drives it.
module softex_lane_sequencer
  import softex_pkg::*;
#(
  parameter int unsigned NUM_LANES  = softex_pkg::NUM_LANES,
  parameter int unsigned VECT_WIDTH = softex_pkg::VECT_WIDTH,
  parameter int unsigned LEN_WIDTH  = softex_pkg::LEN_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            start_i,
  input  logic [LEN_WIDTH-1:0]            len_i,
  input  logic [NUM_LANES-1:0]            lane_valid_i,
  input  logic [NUM_LANES-1:0]            lane_ready_i,
  input  logic [NUM_LANES-1:0]            lane_done_i,
  output logic [NUM_LANES-1:0]            lane_start_o,
  output logic [NUM_LANES-1:0]            lane_last_o,
  output logic [NUM_LANES*VECT_WIDTH-1:0] lane_strb_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam int unsigned E   = NUM_LANES * VECT_WIDTH;
  localparam int unsigned ESH = $clog2(E);

  seq_state_e           state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [NUM_LANES-1:0] lane_start_q;
  logic [NUM_LANES-1:0] done_seen_q;

  logic [LEN_WIDTH:0]   len_ext;
  logic [LEN_WIDTH-1:0] b_w;
  logic [ESH:0]         rem;
  logic [NUM_LANES-1:0] geom_act;
  logic [NUM_LANES-1:0] active;
  logic [NUM_LANES-1:0] fin;
  logic [NUM_LANES-1:0] err_hit;
  logic [NUM_LANES-1:0] done_next;
  logic                 load;
  logic                 run;
  logic                 cnt_en;

  // B = ceil(len/E) with one guard bit; rem = len - (B-1)*E lies in 1..E for len > 0.
  assign len_ext = {1'b0, len_i} + (LEN_WIDTH+1)'(E - 1);
  assign b_w     = LEN_WIDTH'(len_ext >> ESH);
  assign rem     = (ESH+1)'(len_i - ((b_w - LEN_WIDTH'(1)) << ESH));

  assign load      = (state_q == IDLE) & start_i & (len_i != '0);
  assign run       = (state_q == RUN);
  assign cnt_en    = (state_q == RUN) | (state_q == DRAIN);
  assign done_next = done_seen_q | (lane_done_i & active);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [ESH:0] LO = (ESH+1)'(i * VECT_WIDTH);
    localparam logic [ESH:0] VW = (ESH+1)'(VECT_WIDTH);
    lane_geom_t   geom;
    logic [ESH:0] diff;

    // Lanes whose first element index falls below rem get the extra beat.
    always_comb begin
      diff = rem - LO;
      if (rem > LO) begin
        geom.beats    = b_w;
        geom.last_cnt = (diff >= VW) ? VW[CNT_WIDTH-1:0] : diff[CNT_WIDTH-1:0];
      end else begin
        geom.beats    = b_w - LEN_WIDTH'(1);
        geom.last_cnt = VW[CNT_WIDTH-1:0];
      end
    end

    assign geom_act[i] = (geom.beats != '0);

    softex_lane_beat_counter u_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .load_i   (load),
      .geom_i   (geom),
      .cnt_en_i (cnt_en),
      .run_i    (run),
      .valid_i  (lane_valid_i[i]),
      .ready_i  (lane_ready_i[i]),
      .active_o (active[i]),
      .fin_o    (fin[i]),
      .last_o   (lane_last_o[i]),
      .strb_o   (lane_strb_o[i*VECT_WIDTH +: VECT_WIDTH]),
      .err_o    (err_hit[i])
    );
  end

  // Job FSM with registered busy/done/start outputs, sticky error and done capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      lane_start_q <= '0;
      done_seen_q  <= '0;
    end else if (clear_i) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      lane_start_q <= '0;
      done_seen_q  <= '0;
    end else begin
      lane_start_q <= '0;
      done_q       <= 1'b0;
      if (|err_hit) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            err_q       <= 1'b0;
            done_seen_q <= '0;
            if (len_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= START;
              busy_q       <= 1'b1;
              lane_start_q <= geom_act;
            end
          end
        end
        START: begin
          done_seen_q <= done_next;
          state_q     <= RUN;
        end
        RUN: begin
          done_seen_q <= done_next;
          if (&fin) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          done_seen_q <= done_next;
          if (&(done_next | ~active)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lane_start_o = lane_start_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
